// File: rtl/life_gen_engine_pkg.sv
// Shared types and Game-of-Life rule constants for the generation engine.
package life_gen_engine_pkg;

  typedef enum logic [2:0] {IDLE, FILL_A, FILL_B, FILL_C, RD, WR} state_t;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  function automatic logic cell_next(input logic alive, input logic [3:0] n);
    return alive ? ((n >= SURVIVE_LO) && (n <= SURVIVE_HI)) : (n == BIRTH);
  endfunction

endpackage

// File: rtl/life_gen_engine_if.sv
// Control, status and row-memory bundle between the engine (master) and its host (slave).
interface life_gen_engine_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16
);
  localparam int ADDR_W = $clog2(HEIGHT);
  localparam int LIVE_W = $clog2(WIDTH*HEIGHT+1);

  logic              start;
  logic              run;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic [GEN_W-1:0]  gen_count;
  logic [LIVE_W-1:0] live_count;
  logic              stable;

  modport master (
    input  start, run, mem_rdata,
    output busy, done, mem_addr, mem_re, mem_we, mem_wdata, gen_count, live_count, stable
  );

  modport slave (
    output start, run, mem_rdata,
    input  busy, done, mem_addr, mem_re, mem_we, mem_wdata, gen_count, live_count, stable
  );
endinterface

// File: rtl/life_row_next.sv
// Combinational next-generation row from a 3-row window; column edges wrap or read dead.
module life_row_next
  import life_gen_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] nxt
);

  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    localparam int CL   = (c == 0) ? WIDTH-1 : c-1;
    localparam int CH   = (c == WIDTH-1) ? 0 : c+1;
    localparam bit EN_L = WRAP || (c != 0);
    localparam bit EN_H = WRAP || (c != WIDTH-1);

    logic [7:0] nb;
    logic [3:0] sum;

    // Edge neighbours are masked rather than wrapped when the board has dead borders.
    assign nb  = {above[CL] & EN_L, above[c], above[CH] & EN_H,
                  cur[CL]   & EN_L,           cur[CH]   & EN_H,
                  below[CL] & EN_L, below[c], below[CH] & EN_H};
    assign sum = 4'($countones(nb));
    assign nxt[c] = cell_next(cur[c], sum);
  end

endmodule

// File: rtl/life_gen_engine.sv
// Game-of-Life generation sequencer: walks the row RAM with a 3-row window, one generation per start.
module life_gen_engine
  import life_gen_engine_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter bit WRAP   = 1'b1,
  parameter int GEN_W  = 16
) (
  input logic               ph1,
  input logic               reset,
  life_gen_engine_if.master bus
);

  localparam int ADDR_W = $clog2(HEIGHT);
  localparam int LIVE_W = $clog2(WIDTH*HEIGHT+1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(HEIGHT-1);

  state_t            state, nxt;
  logic [ADDR_W-1:0] row, row_nxt;
  logic [WIDTH-1:0]  above, cur, row0, below, next_row;
  logic [LIVE_W-1:0] live_acc, row_pop;
  logic              chg, row_chg;

  logic              re_d, we_d, re_q, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              done_q, stable_q;
  logic [GEN_W-1:0]  gen_q;
  logic [LIVE_W-1:0] live_q;

  // State register plus registered memory strobes (decoded from the upcoming state).
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      row    <= '0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      state  <= nxt;
      row    <= row_nxt;
      re_q   <= re_d;
      we_q   <= we_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    nxt     = state;
    row_nxt = row;
    case (state)
      IDLE:   if (bus.start || bus.run) nxt = FILL_A;
      FILL_A: nxt = FILL_B;
      FILL_B: nxt = FILL_C;
      FILL_C: begin nxt = RD; row_nxt = '0; end
      RD:     nxt = WR;
      WR: begin
        if (row == LAST) begin
          nxt     = IDLE;
          row_nxt = '0;
        end else begin
          nxt     = RD;
          row_nxt = row + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    re_d   = 1'b0;
    we_d   = 1'b0;
    addr_d = '0;
    case (nxt)
      FILL_A: begin re_d = 1'b1; addr_d = LAST; end
      FILL_B: begin re_d = 1'b1; addr_d = '0; end
      RD: begin
        re_d   = (row_nxt < LAST);
        addr_d = re_d ? row_nxt + 1'b1 : row_nxt;
      end
      WR: begin we_d = 1'b1; addr_d = row_nxt; end
      default: ;
    endcase
  end

  // Bottom row's lower neighbour is the saved copy of old row 0, which has been overwritten by now.
  assign below   = (row != LAST) ? bus.mem_rdata : (WRAP ? row0 : '0);
  assign row_chg = (next_row != cur);

  life_row_next #(.WIDTH(WIDTH), .WRAP(WRAP)) u_next (
    .above (above),
    .cur   (cur),
    .below (below),
    .nxt   (next_row)
  );

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < WIDTH; i++) row_pop = row_pop + LIVE_W'(next_row[i]);
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      above    <= '0;
      cur      <= '0;
      row0     <= '0;
      live_acc <= '0;
      chg      <= 1'b0;
      done_q   <= 1'b0;
      gen_q    <= '0;
      live_q   <= '0;
      stable_q <= 1'b0;
    end else begin
      done_q <= (state == WR) && (row == LAST);
      case (state)
        FILL_A: begin
          live_acc <= '0;
          chg      <= 1'b0;
        end
        FILL_B: above <= WRAP ? bus.mem_rdata : '0;
        FILL_C: begin
          cur  <= bus.mem_rdata;
          row0 <= bus.mem_rdata;
        end
        WR: begin
          above    <= cur;
          cur      <= below;
          live_acc <= live_acc + row_pop;
          chg      <= chg | row_chg;
          if (row == LAST) begin
            gen_q    <= gen_q + 1'b1;
            live_q   <= live_acc + row_pop;
            stable_q <= ~(chg | row_chg);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.mem_re     = re_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = (state == WR) ? next_row : '0;
  assign bus.gen_count  = gen_q;
  assign bus.live_count = live_q;
  assign bus.stable     = stable_q;

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: dead-edge and toroidal engines run side by side against a whole-board model.
module tb_life_gen_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int GW = 16;

  typedef logic [H-1:0][W-1:0] board_t;

  logic ph1   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic run   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int gexp     = 0;

  board_t exp0, exp1;
  board_t ld_b0, ld_b1;
  logic   ld = 1'b0;
  logic [W-1:0] mem0 [H];
  logic [W-1:0] mem1 [H];

  always #5 ph1 = ~ph1;

  life_gen_engine_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) ifc0();
  life_gen_engine_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) ifc1();

  assign ifc0.start = start;
  assign ifc0.run   = run;
  assign ifc1.start = start;
  assign ifc1.run   = run;

  life_gen_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b0), .GEN_W(GW)) dut0 (
    .ph1(ph1), .reset(reset), .bus(ifc0.master));
  life_gen_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b1), .GEN_W(GW)) dut1 (
    .ph1(ph1), .reset(reset), .bus(ifc1.master));

  // Single-port row RAMs, one-cycle read latency.
  always @(posedge ph1) begin
    if (ld) begin
      for (int i = 0; i < H; i++) begin
        mem0[i] <= ld_b0[i];
        mem1[i] <= ld_b1[i];
      end
    end else begin
      if (ifc0.mem_we) mem0[ifc0.mem_addr] <= ifc0.mem_wdata;
      if (ifc1.mem_we) mem1[ifc1.mem_addr] <= ifc1.mem_wdata;
    end
    if (ifc0.mem_re) ifc0.mem_rdata <= mem0[ifc0.mem_addr];
    if (ifc1.mem_re) ifc1.mem_rdata <= mem1[ifc1.mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic board_t life_step(input board_t b, input bit wrap);
    board_t n;
    int s, rr, cc;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < H && cc >= 0 && cc < W)
              s += int'(b[rr][cc]);
          end
        n[r][c] = (s == 3) || (b[r][c] && s == 2);
      end
    return n;
  endfunction

  function automatic board_t rd_mem(input bit s);
    board_t b;
    for (int i = 0; i < H; i++) b[i] = s ? mem1[i] : mem0[i];
    return b;
  endfunction

  function automatic logic [63:0] outs0();
    return 64'({ifc0.busy, ifc0.done, ifc0.mem_re, ifc0.mem_we, ifc0.mem_addr,
                ifc0.mem_wdata, ifc0.gen_count, ifc0.live_count, ifc0.stable});
  endfunction

  function automatic logic [63:0] outs1();
    return 64'({ifc1.busy, ifc1.done, ifc1.mem_re, ifc1.mem_we, ifc1.mem_addr,
                ifc1.mem_wdata, ifc1.gen_count, ifc1.live_count, ifc1.stable});
  endfunction

  // Strobe sanity on every cycle out of reset.
  always @(negedge ph1) begin
    if (!reset) begin
      chk("excl0", ifc0.mem_re & ifc0.mem_we, 1'b0);
      chk("excl1", ifc1.mem_re & ifc1.mem_we, 1'b0);
      chk("idle0", !ifc0.busy & (ifc0.mem_re | ifc0.mem_we), 1'b0);
      chk("idle1", !ifc1.busy & (ifc1.mem_re | ifc1.mem_we), 1'b0);
    end
  end

  task automatic load(input board_t b0, input board_t b1);
    ld_b0 = b0;
    ld_b1 = b1;
    ld    = 1'b1;
    @(negedge ph1);
    ld    = 1'b0;
    exp0  = b0;
    exp1  = b1;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (ifc0.done !== 1'b1 && cyc < 200) begin
      @(negedge ph1);
      cyc++;
    end
    chk({tag, ".done0"}, ifc0.done, 1'b1);
    chk({tag, ".done1"}, ifc1.done, 1'b1);
  endtask

  task automatic gen_done_checks(input string tag);
    board_t p0, p1;
    p0 = exp0;
    p1 = exp1;
    exp0 = life_step(p0, 1'b0);
    exp1 = life_step(p1, 1'b1);
    gexp++;
    chk({tag, ".brd0"},   rd_mem(1'b0), exp0);
    chk({tag, ".brd1"},   rd_mem(1'b1), exp1);
    chk({tag, ".live0"},  ifc0.live_count, $countones(exp0));
    chk({tag, ".live1"},  ifc1.live_count, $countones(exp1));
    chk({tag, ".stab0"},  ifc0.stable, (p0 == exp0));
    chk({tag, ".stab1"},  ifc1.stable, (p1 == exp1));
    chk({tag, ".gen0"},   ifc0.gen_count, gexp % (1 << GW));
    chk({tag, ".gen1"},   ifc1.gen_count, gexp % (1 << GW));
  endtask

  task automatic one_gen(input string tag);
    int cyc;
    start = 1'b1;
    @(posedge ph1);
    @(negedge ph1);
    start = 1'b0;
    chk({tag, ".busy"}, ifc0.busy, 1'b1);
    wait_done(tag, cyc);
    chk({tag, ".lat"}, cyc, 3 + 2*H);
    gen_done_checks(tag);
  endtask

  initial begin
    board_t b, g, old0, old1, n0, n1, m0, m1;
    int cyc, cnt, last;

    repeat (2) @(negedge ph1);
    chk("rst.outs0", outs0(), 64'd0);
    chk("rst.outs1", outs1(), 64'd0);
    reset = 1'b0;
    @(negedge ph1);

    // Vertical blinker at column 3
    b = '0;
    b[2] = 8'h08; b[3] = 8'h08; b[4] = 8'h08;
    load(b, b);
    one_gen("blinker");
    chk("blinker.row3", mem0[3], 8'b0001_1100);
    chk("blinker.row2", mem0[2], 8'h00);
    chk("blinker.row4", mem0[4], 8'h00);
    chk("blinker.live", ifc0.live_count, 3);
    chk("blinker.stab", ifc0.stable, 1'b0);

    // 2x2 block in the corner
    b = '0;
    b[0] = 8'h03; b[1] = 8'h03;
    load(b, b);
    one_gen("block");
    chk("block.same", rd_mem(1'b0), b);
    chk("block.stab", ifc0.stable, 1'b1);
    chk("block.live", ifc0.live_count, 4);

    // Horizontal triple split across the column edge
    b = '0;
    b[0] = 8'b1100_0001;
    load(b, b);
    one_gen("edge");

    for (int k = 0; k < 4; k++) begin
      b = {$urandom, $urandom};
      load(b, b ^ {$urandom, $urandom});
      one_gen("rand_a");
      one_gen("rand_b");
    end

    // start ignored while busy, accepted in the done cycle
    b = {$urandom, $urandom};
    load(b, b);
    start = 1'b1;
    @(posedge ph1);
    @(negedge ph1);
    start = 1'b0;
    repeat (5) @(negedge ph1);
    start = 1'b1;
    @(negedge ph1);
    start = 1'b0;
    wait_done("busy_start", cyc);
    start = 1'b1;
    gen_done_checks("busy_start");
    @(posedge ph1);
    @(negedge ph1);
    start = 1'b0;
    chk("at_done.busy", ifc0.busy, 1'b1);
    wait_done("at_done", cyc);
    chk("at_done.lat", cyc, 3 + 2*H);
    gen_done_checks("at_done");

    // run dropped mid-generation finishes that generation only
    run = 1'b1;
    @(posedge ph1);
    @(negedge ph1);
    repeat (6) @(negedge ph1);
    run = 1'b0;
    wait_done("run_clr", cyc);
    gen_done_checks("run_clr");
    repeat (30) @(negedge ph1);
    chk("run_clr.idle", ifc0.busy | ifc1.busy, 1'b0);
    chk("run_clr.gen", ifc0.gen_count, gexp);

    // Glider straddling the corner, free-running 32 generations
    g = '0;
    g[6] = 8'b1000_0000;
    g[7] = 8'b0000_0001;
    g[0] = 8'b1100_0001;
    load(g, g);
    run = 1'b1;
    cnt = 0; last = 0; cyc = 0;
    while (cnt < 32 && cyc < 32*20 + 60) begin
      @(negedge ph1);
      cyc++;
      if (ifc0.done) begin
        cnt++;
        if (cnt == 32) run = 1'b0;
        if (cnt > 1) chk("glider.period", cyc - last, 4 + 2*H);
        last = cyc;
        gen_done_checks("glider");
      end
    end
    run = 1'b0;
    chk("glider.count", cnt, 32);
    chk("glider.home", rd_mem(1'b1), g);
    repeat (25) @(negedge ph1);
    chk("glider.stop", ifc1.busy, 1'b0);

    // Reset during WR(4)
    old0 = {$urandom, $urandom};
    old1 = {$urandom, $urandom};
    load(old0, old1);
    start = 1'b1;
    @(posedge ph1);
    @(negedge ph1);
    start = 1'b0;
    repeat (12) @(negedge ph1);
    chk("rstwr.we", ifc0.mem_we, 1'b1);
    chk("rstwr.addr", ifc0.mem_addr, 4);
    reset = 1'b1;
    #1;
    chk("rstwr.now0", outs0(), 64'd0);
    chk("rstwr.now1", outs1(), 64'd0);
    @(negedge ph1);
    chk("rstwr.next0", outs0(), 64'd0);
    chk("rstwr.next1", outs1(), 64'd0);
    n0 = life_step(old0, 1'b0);
    n1 = life_step(old1, 1'b1);
    for (int i = 0; i < H; i++) begin
      m0[i] = (i < 4) ? n0[i] : old0[i];
      m1[i] = (i < 4) ? n1[i] : old1[i];
    end
    chk("rstwr.mem0", rd_mem(1'b0), m0);
    chk("rstwr.mem1", rd_mem(1'b1), m1);
    reset = 1'b0;
    gexp = 0;
    repeat (3) @(negedge ph1);
    chk("rstwr.idle", ifc0.busy | ifc1.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
